// File: rtl/pfb_div_pkg.sv
// pfb_div_pkg: shared widths and FSM state for the sequential unsigned divider.
package pfb_div_pkg;
  localparam int DIVIDEND_W = 23;
  localparam int DIVISOR_W = 13;
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/pfb_udiv_step.sv
// pfb_udiv_step: one combinational restoring-division iteration.
module pfb_udiv_step #(
  parameter int W = 13
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);
  logic [W+1:0] trial;
  assign trial = {rem_in, bit_in};
  assign q_bit = trial >= (W+2)'(divisor);
  // with a zero divisor this keeps shifting the dividend through, leaving its low bits
  assign rem_out = (W+1)'(q_bit ? trial - (W+2)'(divisor) : trial);
endmodule

// File: rtl/pfb_multichannel_udiv_23ns_13ns_seq.sv
// pfb_multichannel_udiv_23ns_13ns_seq: fixed-latency sequential unsigned restoring divider.
module pfb_multichannel_udiv_23ns_13ns_seq
  import pfb_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH = DIVISOR_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);
  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d, quo_q, quo_d;
  logic [DIVISOR_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIVISOR_WIDTH:0] rem_q, rem_d, step_rem;
  logic dbz_q, dbz_d, step_bit;
  pfb_udiv_step #(.W(DIVISOR_WIDTH)) u_step (
    .rem_in(rem_q),
    .bit_in(dvd_q[DIVIDEND_WIDTH-1]),
    .divisor(dvs_q),
    .rem_out(step_rem),
    .q_bit(step_bit)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign quotient = quo_q;
  assign remainder = rem_q[DIVISOR_WIDTH-1:0];
  assign div_by_zero = dbz_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        cnt_d = CW'(DIVIDEND_WIDTH);
        dvd_d = dividend;
        dvs_d = divisor;
        quo_d = '0;
        rem_d = '0;
        dbz_d = 1'b0;
      end
      BUSY: begin
        dvd_d = {dvd_q[DIVIDEND_WIDTH-2:0], 1'b0};
        quo_d = {quo_q[DIVIDEND_WIDTH-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? DONE : BUSY;
        dbz_d = cnt_q == CW'(1) && dvs_q == '0;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
endmodule

// File: tb/tb_pfb_multichannel_udiv_23ns_13ns_seq.sv
// tb_pfb_multichannel_udiv_23ns_13ns_seq: directed and randomized checks against an arithmetic model.
module tb_pfb_multichannel_udiv_23ns_13ns_seq;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [22:0] dividend = '0;
  logic [12:0] divisor = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [22:0] quotient;
  logic [12:0] remainder;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 ap_clk = ~ap_clk;
  pfb_multichannel_udiv_23ns_13ns_seq dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [22:0] ref_q(input logic [22:0] a, input logic [12:0] b);
    return b == 0 ? 23'h7FFFFF : a / 23'(b);
  endfunction
  function automatic logic [12:0] ref_r(input logic [22:0] a, input logic [12:0] b);
    return b == 0 ? a[12:0] : 13'(a % 23'(b));
  endfunction
  // Entered and left at a falling edge; noise drives junk operands/in_valid while the divider is busy.
  task automatic run_op(input logic [22:0] a, input logic [12:0] b, input int hold, input bit noise);
    int lat;
    int busy_rdy;
    logic [22:0] eq;
    logic [12:0] er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    out_ready = noise ? 1'($urandom) : (hold == 0);
    chk("accept_ready", 32'(in_ready), 1);
    @(posedge ap_clk);
    lat = 0;
    busy_rdy = 0;
    forever begin
      @(negedge ap_clk);
      if (out_valid || lat >= 60) break;
      lat++;
      if (in_ready) busy_rdy++;
      in_valid = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        dividend = 23'($urandom);
        divisor = 13'($urandom);
        out_ready = 1'($urandom);
      end
    end
    chk("latency", 32'(lat), 23);
    chk("busy_in_ready", 32'(busy_rdy), 0);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(b == 0));
    out_ready = hold == 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_quotient", 32'(quotient), 32'(eq));
      chk("stall_remainder", 32'(remainder), 32'(er));
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    chk("release_valid", 32'(out_valid), 0);
    chk("release_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
  endtask
  initial begin
    logic [22:0] ra;
    logic [12:0] rb;
    in_valid = 1'b1;
    dividend = 23'd77;
    divisor = 13'd5;
    repeat (3) @(negedge ap_clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    ap_rst = 1'b0;
    in_valid = 1'b0;
    @(negedge ap_clk);
    run_op(23'd1000, 13'd7, 0, 1'b0);
    run_op(23'd8388607, 13'd8191, 0, 1'b0);
    run_op(23'd5000000, 13'd5000, 0, 1'b0);
    run_op(23'd5, 13'd9, 0, 1'b0);
    run_op(23'd12345, 13'd0, 0, 1'b0);
    run_op(23'd1000, 13'd7, 5, 1'b0);
    run_op(23'd0, 13'd1, 0, 1'b0);
    in_valid = 1'b1;
    dividend = 23'd100;
    divisor = 13'd3;
    @(posedge ap_clk);
    repeat (10) @(negedge ap_clk);
    in_valid = 1'b1;
    dividend = 23'd999;
    divisor = 13'd4;
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_quotient", 32'(quotient), 0);
    chk("midrst_remainder", 32'(remainder), 0);
    chk("midrst_dbz", 32'(div_by_zero), 0);
    ap_rst = 1'b0;
    in_valid = 1'b0;
    run_op(23'd100, 13'd3, 0, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      ra = 23'($urandom);
      rb = 13'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 13'd1;
        1: ra = '0;
        2: rb = '0;
        3: rb = 13'($urandom_range(1, 15));
        4: ra = 23'($urandom_range(0, 9000));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge ap_clk);
      run_op(ra, rb, $urandom_range(0, 3), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
